// File: rtl/sipo_frame_rx.sv
// Serial-in/parallel-out frame receiver: WIDTH-bit frames shifted in on shift_en,
// handed to a valid/ready holding register with sticky overrun on dropped frames.
module sipo_frame_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             shift_en,
  input  logic             clear,
  output logic [WIDTH-1:0] rshift,
  output logic [CW-1:0]    bit_cnt,
  output logic             busy,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             overrun
);

  logic [WIDTH-1:0] rshift_nxt;
  logic             last_bit;

  always_comb begin
    rshift_nxt = '0;
    if (MSB_FIRST) rshift_nxt = {rshift[WIDTH-2:0], si};
    else           rshift_nxt = {si, rshift[WIDTH-1:1]};
  end

  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
  assign busy     = (bit_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rshift   <= '0;
      bit_cnt  <= '0;
      po       <= '0;
      po_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      // A consume drops valid unless a completion later in this block refills it.
      if (po_valid && po_ready) po_valid <= 1'b0;

      if (clear) begin
        rshift  <= '0;
        bit_cnt <= '0;
        overrun <= 1'b0;
      end else if (shift_en) begin
        rshift <= rshift_nxt;
        if (last_bit) begin
          bit_cnt <= '0;
          if (!po_valid || po_ready) begin
            po       <= rshift_nxt;
            po_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

endmodule
